// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bundle and scheduler state type
// for the ALU scheduler and its arbiter.
package alu_pkg;

   localparam logic [7:0] ADD                = 8'd0;
   localparam logic [7:0] SUBTRACT           = 8'd1;
   localparam logic [7:0] MULTIPLY           = 8'd2;
   localparam logic [7:0] EQUALS             = 8'd3;
   localparam logic [7:0] GREATER_THAN       = 8'd4;
   localparam logic [7:0] ADD_IMMEDIATE      = 8'd9;
   localparam logic [7:0] SUBTRACT_IMMEDIATE = 8'd10;
   localparam logic [7:0] MOV                = 8'd11;

   typedef struct packed {
      logic overflow;
      logic carry;
      logic zero;
      logic sign;
      logic parity;
   } flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_in.
// Ports: req_in (request vector), ptr_in (start index),
//        grant_out (one-hot), any_grant_out (some request won).
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_in,
   input  logic [ID_W-1:0]    ptr_in,
   output logic [NUM_REQ-1:0] grant_out,
   output logic               any_grant_out
);

   logic [ID_W:0] w_idx;
   logic          w_found;

   always_comb begin
      grant_out = '0;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // candidate index = (ptr + k) mod NUM_REQ
         w_idx = {1'b0, ptr_in} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
            w_idx = w_idx - (ID_W+1)'(NUM_REQ);
         end
         if (!w_found && req_in[w_idx[ID_W-1:0]]) begin
            grant_out[w_idx[ID_W-1:0]] = 1'b1;
            w_found = 1'b1;
         end
      end
   end

   assign any_grant_out = |grant_out;

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational ALU among requesters.
// Ports: clk_in/reset_in; req_* valid/ready request channels;
//        resp_* valid/ready response channel; alu_* ALU drive/return.
module alu_scheduler
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                           clk_in,
   input  logic                           reset_in,
   input  logic [NUM_REQ-1:0]             req_valid_in,
   output logic [NUM_REQ-1:0]             req_ready_out,
   input  logic [NUM_REQ-1:0][7:0]        req_opcode_in,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_operand1_in,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_operand2_in,
   output logic                           resp_valid_out,
   input  logic                           resp_ready_in,
   output logic [ID_W-1:0]                resp_id_out,
   output logic [DATA_W-1:0]              resp_result_out,
   output logic [4:0]                     resp_flags_out,
   output logic                           alu_enable_out,
   output logic [7:0]                     alu_opcode_out,
   output logic [DATA_W-1:0]              alu_input1_out,
   output logic [DATA_W-1:0]              alu_input2_out,
   input  logic [DATA_W-1:0]              alu_output_in,
   input  logic [4:0]                     alu_flags_in
);

   sched_state_t      r_state;
   logic [ID_W-1:0]   r_ptr;
   logic [ID_W-1:0]   r_id;
   logic [7:0]        r_op;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_res;
   flags_t            r_flg;

   logic [NUM_REQ-1:0] w_grant;
   logic               w_any;
   logic [ID_W-1:0]    w_win;
   logic [ID_W-1:0]    w_ptr_nxt;
   logic               w_live;
   logic               w_idle;
   logic               w_exec;
   logic               w_rv;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req_in        (req_valid_in),
      .ptr_in        (r_ptr),
      .grant_out     (w_grant),
      .any_grant_out (w_any)
   );

   always_comb begin
      w_win = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_grant[k]) begin
            w_win = ID_W'(k);
         end
      end
   end

   assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ-1)) ? '0
                    : w_win + ID_W'(1);

   // Outputs are forced quiet in any cycle reset is asserted,
   // so nothing is granted or reported during reset.
   assign w_live = !reset_in;
   assign w_idle = w_live && (r_state == IDLE);
   assign w_exec = w_live && (r_state == EXEC);
   assign w_rv   = w_live && (r_state == RESP);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_flg   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op    <= req_opcode_in[w_win];
                  r_a     <= req_operand1_in[w_win];
                  r_b     <= req_operand2_in[w_win];
                  r_id    <= w_win;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_res   <= alu_output_in;
               r_flg   <= flags_t'(alu_flags_in);
               r_state <= RESP;
            end
            RESP: begin
               if (resp_ready_in) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready_out   = w_idle ? w_grant : '0;

   assign alu_enable_out  = w_exec;
   assign alu_opcode_out  = w_exec ? r_op : '0;
   assign alu_input1_out  = w_exec ? r_a  : '0;
   assign alu_input2_out  = w_exec ? r_b  : '0;

   assign resp_valid_out  = w_rv;
   assign resp_id_out     = w_rv ? r_id  : '0;
   assign resp_result_out = w_rv ? r_res : '0;
   assign resp_flags_out  = w_rv ? r_flg : '0;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed scenarios plus
// randomized traffic checked against a transaction-level model.
module tb_alu_scheduler;
   import alu_pkg::*;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset_in;
   logic [N-1:0]           req_valid_in;
   logic [N-1:0]           req_ready_out;
   logic [N-1:0][7:0]      req_opcode_in;
   logic [N-1:0][DW-1:0]   req_operand1_in;
   logic [N-1:0][DW-1:0]   req_operand2_in;
   logic                   resp_valid_out;
   logic                   resp_ready_in;
   logic [IW-1:0]          resp_id_out;
   logic [DW-1:0]          resp_result_out;
   logic [4:0]             resp_flags_out;
   logic                   alu_enable_out;
   logic [7:0]             alu_opcode_out;
   logic [DW-1:0]          alu_input1_out;
   logic [DW-1:0]          alu_input2_out;
   logic [DW-1:0]          alu_output_in;
   logic [4:0]             alu_flags_in;

   int checks = 0;
   int errors = 0;

   alu_scheduler #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
      .clk_in          (clk),
      .reset_in        (reset_in),
      .req_valid_in    (req_valid_in),
      .req_ready_out   (req_ready_out),
      .req_opcode_in   (req_opcode_in),
      .req_operand1_in (req_operand1_in),
      .req_operand2_in (req_operand2_in),
      .resp_valid_out  (resp_valid_out),
      .resp_ready_in   (resp_ready_in),
      .resp_id_out     (resp_id_out),
      .resp_result_out (resp_result_out),
      .resp_flags_out  (resp_flags_out),
      .alu_enable_out  (alu_enable_out),
      .alu_opcode_out  (alu_opcode_out),
      .alu_input1_out  (alu_input1_out),
      .alu_input2_out  (alu_input2_out),
      .alu_output_in   (alu_output_in),
      .alu_flags_in    (alu_flags_in)
   );

   // Stand-in ALU: returns {flags, result}
   function automatic logic [12:0] alu_f(logic [7:0] op,
                                         logic [7:0] a,
                                         logic [7:0] b);
      logic [8:0] w;
      logic       v;
      logic [7:0] r;
      w = '0;
      v = 1'b0;
      case (op)
         ADD, ADD_IMMEDIATE: begin
            w = {1'b0, a} + {1'b0, b};
            v = (a[7] == b[7]) && (w[7] != a[7]);
         end
         SUBTRACT, SUBTRACT_IMMEDIATE: begin
            w = {1'b0, a} - {1'b0, b};
            v = (a[7] != b[7]) && (w[7] != a[7]);
         end
         EQUALS:       w = {8'd0, (a == b)};
         GREATER_THAN: w = {8'd0, (a > b)};
         MOV:          w = {1'b0, b};
         default:      w = '0;
      endcase
      r = w[7:0];
      return {v, w[8], (r == 8'd0), r[7], ^r, r};
   endfunction

   always_comb begin
      {alu_flags_in, alu_output_in} =
         alu_f(alu_opcode_out, alu_input1_out, alu_input2_out);
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Transaction model: idle / one cycle of ALU use / waiting response
   int         m_ptr  = 0;
   bit         m_busy = 0;
   int         m_age  = 0;
   int         m_id   = 0;
   logic [7:0] m_op, m_a, m_b, m_res;
   logic [4:0] m_flg;

   always @(negedge clk) begin
      logic [N-1:0] e_rdy;
      logic         e_en, e_rv;
      logic [7:0]   e_op, e_a, e_b, e_res;
      logic [4:0]   e_flg;
      int           e_id;
      int           j;
      bit           got;
      e_rdy = '0; e_en = 0; e_rv = 0;
      e_op = 0; e_a = 0; e_b = 0; e_res = 0; e_flg = 0; e_id = 0;
      got = 0;
      if (reset_in) begin
         m_busy = 0;
         m_ptr  = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!got && req_valid_in[j]) begin
               got      = 1;
               e_rdy[j] = 1'b1;
               m_id     = j;
               m_op     = req_opcode_in[j];
               m_a      = req_operand1_in[j];
               m_b      = req_operand2_in[j];
               m_ptr    = (j + 1) % N;
               m_busy   = 1;
               m_age    = 1;
            end
         end
      end else if (m_age == 1) begin
         e_en = 1; e_op = m_op; e_a = m_a; e_b = m_b;
         {m_flg, m_res} = alu_f(m_op, m_a, m_b);
         m_age = 2;
      end else begin
         e_rv = 1; e_id = m_id; e_res = m_res; e_flg = m_flg;
         if (resp_ready_in) m_busy = 0;
      end
      chk("m_req_ready",  req_ready_out,   e_rdy);
      chk("m_alu_en",     alu_enable_out,  e_en);
      chk("m_alu_op",     alu_opcode_out,  e_op);
      chk("m_alu_in1",    alu_input1_out,  e_a);
      chk("m_alu_in2",    alu_input2_out,  e_b);
      chk("m_resp_valid", resp_valid_out,  e_rv);
      chk("m_resp_id",    resp_id_out,     e_id);
      chk("m_resp_res",   resp_result_out, e_res);
      chk("m_resp_flags", resp_flags_out,  e_flg);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [7:0] ops [10] = '{ADD, SUBTRACT, MULTIPLY, EQUALS,
                            GREATER_THAN, ADD_IMMEDIATE,
                            SUBTRACT_IMMEDIATE, MOV, 8'd5, 8'hFF};

   task automatic rand_req(int i);
      req_valid_in[i]    = 1'($urandom_range(0, 1));
      req_opcode_in[i]   = ops[$urandom_range(0, 9)];
      req_operand1_in[i] = 8'($urandom);
      req_operand2_in[i] = 8'($urandom);
   endtask

   task automatic set_req(int i, logic [7:0] op,
                          logic [7:0] a, logic [7:0] b);
      req_valid_in[i]    = 1'b1;
      req_opcode_in[i]   = op;
      req_operand1_in[i] = a;
      req_operand2_in[i] = b;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   int           ids  [5];
   logic [7:0]   ress [5];
   int           tcyc [5];
   int           n;
   logic [N-1:0] granted;

   initial begin
      reset_in        = 1'b1;
      resp_ready_in   = 1'b1;
      req_valid_in    = '0;
      req_opcode_in   = '0;
      req_operand1_in = '0;
      req_operand2_in = '0;

      // reset with everyone requesting
      for (int i = 0; i < N; i++) set_req(i, MOV, 8'(10+i), 8'(10+i));
      @(negedge clk);
      chk("rst_ready", req_ready_out, 4'b0000);
      chk("rst_alu_en", alu_enable_out, 0);
      @(negedge clk);
      chk("rst_resp_valid", resp_valid_out, 0);
      nxt(); reset_in = 1'b0;
      @(negedge clk);
      chk("first_grant", req_ready_out, 4'b0001);
      nxt(); req_valid_in = '0;
      @(negedge clk);
      chk("first_exec_en", alu_enable_out, 1);
      @(negedge clk);
      chk("first_resp_id", resp_id_out, 0);
      chk("first_resp_res", resp_result_out, 10);
      nxt();

      // single add from requester 2
      set_req(2, ADD, 8'd100, 8'd27);
      @(negedge clk);
      chk("add_ready", req_ready_out, 4'b0100);
      nxt(); req_valid_in[2] = 1'b0;
      @(negedge clk);
      chk("add_ready_low", req_ready_out, 4'b0000);
      chk("add_alu_in1", alu_input1_out, 100);
      @(negedge clk);
      chk("add_valid", resp_valid_out, 1);
      chk("add_id", resp_id_out, 2);
      chk("add_result", resp_result_out, 127);
      chk("add_flags", resp_flags_out, 5'b00001);
      nxt();

      // signed overflow subtract from requester 1
      set_req(1, SUBTRACT, 8'h80, 8'h01);
      @(negedge clk);
      chk("sub_ready", req_ready_out, 4'b0010);
      nxt(); req_valid_in[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sub_id", resp_id_out, 1);
      chk("sub_result", resp_result_out, 8'h7F);
      chk("sub_flags", resp_flags_out, 5'b10001);
      nxt();

      // fairness after a pointer-clearing reset pulse
      reset_in = 1'b1;
      nxt();
      reset_in = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, MOV, 8'(10+i), 8'(10+i));
      n = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         @(negedge clk);
         if (resp_valid_out && resp_ready_in) begin
            ids[n] = int'(resp_id_out);
            ress[n] = resp_result_out;
            tcyc[n] = c;
            n++;
         end
      end
      nxt(); req_valid_in = '0;
      chk("fair_count", n, 5);
      for (int k = 0; k < n; k++) begin
         chk("fair_id", ids[k], k % 4);
         chk("fair_res", ress[k], 10 + (k % 4));
         if (k > 0) chk("fair_gap", tcyc[k] - tcyc[k-1], 3);
      end

      // backpressure: response held while requester 3 waits
      resp_ready_in = 1'b0;
      set_req(0, ADD, 8'd5, 8'd6);
      @(negedge clk);
      chk("bp_grant0", req_ready_out, 4'b0001);
      nxt();
      req_valid_in[0] = 1'b0;
      set_req(3, EQUALS, 8'd7, 8'd7);
      @(negedge clk);
      chk("bp_exec_ready", req_ready_out, 4'b0000);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", resp_valid_out, 1);
         chk("bp_id", resp_id_out, 0);
         chk("bp_res", resp_result_out, 11);
         chk("bp_ready", req_ready_out, 4'b0000);
      end
      nxt(); resp_ready_in = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", resp_valid_out, 1);
      chk("bp_hs_ready", req_ready_out, 4'b0000);
      nxt();
      @(negedge clk);
      chk("bp_grant3", req_ready_out, 4'b1000);
      nxt(); req_valid_in[3] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("eq_result", resp_result_out, 1);
      nxt();

      // reset while in EXEC
      set_req(1, ADD, 8'd1, 8'd2);
      @(negedge clk);
      chk("mr_grant1", req_ready_out, 4'b0010);
      nxt();
      reset_in = 1'b1;
      set_req(1, MOV, 8'd9, 8'd9);
      set_req(3, MOV, 8'd33, 8'd33);
      @(negedge clk);
      chk("mr_rst_en", alu_enable_out, 0);
      nxt(); reset_in = 1'b0;
      @(negedge clk);
      chk("mr_no_resp", resp_valid_out, 0);
      chk("mr_lowest", req_ready_out, 4'b0010);
      nxt(); req_valid_in = '0;
      nxt();
      nxt();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         granted = req_ready_out;
         nxt();
         reset_in = ($urandom_range(0, 199) == 0);
         resp_ready_in = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (granted[i] || !req_valid_in[i]) begin
               if ($urandom_range(0, 1) == 0) rand_req(i);
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid_in[i] = 1'b0;
            end
         end
      end
      reset_in = 1'b0;
      resp_ready_in = 1'b1;
      req_valid_in = '0;
      repeat (5) nxt();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
